// File: rtl/dsram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsram_responder_pkg
// Brief    : FSM encoding, legal store masks and request type for the
//            data-side SRAM responder. Optional macro: DSRAM_ACCESS_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
package dsram_responder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] WEN_READ = 4'b0000;
   localparam logic [3:0] WEN_B0   = 4'b0001;
   localparam logic [3:0] WEN_B1   = 4'b0010;
   localparam logic [3:0] WEN_B2   = 4'b0100;
   localparam logic [3:0] WEN_B3   = 4'b1000;
   localparam logic [3:0] WEN_H0   = 4'b0011;
   localparam logic [3:0] WEN_H1   = 4'b1100;
   localparam logic [3:0] WEN_W    = 4'b1111;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  wen;
      logic [31:0] wdata;
   } dsram_req_t;

   function automatic logic wen_legal(input logic [3:0] wen);
      logic ok;
      case (wen)
         WEN_READ, WEN_B0, WEN_B1, WEN_B2, WEN_B3,
         WEN_H0, WEN_H1, WEN_W: ok = 1'b1;
         default:               ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dsram_bank.sv
`default_nettype none
// ============================================================================
// Module   : dsram_bank
// Brief    : 2^ADDR_WIDTH x 32-bit byte-lane RAM, per-lane write enable,
//            synchronous read port with read enable, no reset.
// Revision : 1.0  initial release
// ============================================================================
module dsram_bank #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [3:0]            we,
   input  logic                  re,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] r_mem [0:DEPTH-1];
      logic [7:0] r_q;

      // Read data only moves on a read so it holds across writes and idles.
      always_ff @(posedge clk) begin
         if (we[l]) r_mem[addr] <= wdata[8*l +: 8];
         if (re)    r_q         <= r_mem[addr];
      end

      assign rdata[8*l +: 8] = r_q;
   end

endmodule
`default_nettype wire

// File: rtl/dsram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dsram_responder
// Brief    : Data-side SRAM slave with wait states, stall request, error flag.
//            Optional macro DSRAM_ACCESS_CNT_EN enables rd/wr access counters.
// Revision : 1.0  initial release
// ============================================================================
module dsram_responder
   import dsram_responder_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 10,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        resp_valid,
   output logic        addr_err,
   output logic        stallreq_for_mem,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam bit         HAS_WAIT = (WAIT_CYCLES != 0);
   localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   dsram_req_t  r_req;
   logic        r_resp_valid;
   logic        r_addr_err;
   logic        r_rdata_zero;

   dsram_req_t            w_live;
   dsram_req_t            w_req;
   logic [31:0]           w_offset;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_err;
   logic                  w_go;
   logic                  w_is_read;
   logic [3:0]            w_we;
   logic                  w_re;
   logic [31:0]           w_bank_q;
   logic                  w_unused;

   assign w_live = '{addr: data_sram_addr, wen: data_sram_wen, wdata: data_sram_wdata};
   assign w_req  = (r_state == ST_WAIT) ? r_req : w_live;

   // An address below BASE_ADDR wraps to a huge offset, so one upper-bit test covers both bounds.
   assign w_offset  = w_req.addr - BASE_ADDR;
   assign w_idx     = w_offset[ADDR_WIDTH+1:2];
   assign w_err     = (|w_offset[31:ADDR_WIDTH+2]) || !wen_legal(w_req.wen);
   assign w_unused  = &{1'b0, w_offset[1:0]};
   assign w_is_read = (w_req.wen == WEN_READ);

   assign w_go = ((r_state == ST_IDLE) && data_sram_en && !HAS_WAIT) ||
                 ((r_state == ST_WAIT) && (r_cnt == 4'd0));
   assign w_we = (w_go && !w_err) ? w_req.wen : 4'b0000;
   assign w_re = w_go && !w_err && w_is_read;

   dsram_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
      .clk   (clk),
      .addr  (w_idx),
      .we    (w_we),
      .re    (w_re),
      .wdata (w_req.wdata),
      .rdata (w_bank_q)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 4'd0;
         r_req        <= '0;
         r_resp_valid <= 1'b0;
         r_addr_err   <= 1'b0;
         r_rdata_zero <= 1'b1;
      end else begin
         r_resp_valid <= 1'b0;
         r_addr_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (data_sram_en && HAS_WAIT) begin
                  r_req   <= w_live;
                  r_cnt   <= CNT_INIT;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) r_state <= ST_DONE;
               else               r_cnt   <= r_cnt - 4'd1;
            end
            // The requester still holds the request this cycle; it is not a new one.
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
         if (w_go) begin
            r_resp_valid <= 1'b1;
            r_addr_err   <= w_err;
            if (w_err)          r_rdata_zero <= 1'b1;
            else if (w_is_read) r_rdata_zero <= 1'b0;
         end
      end
   end

   assign data_sram_rdata  = r_rdata_zero ? 32'd0 : w_bank_q;
   assign resp_valid       = r_resp_valid;
   assign addr_err         = r_addr_err;
   assign stallreq_for_mem = resetn &&
                             (((r_state == ST_IDLE) && data_sram_en && HAS_WAIT) ||
                              (r_state == ST_WAIT));

`ifdef DSRAM_ACCESS_CNT_EN
   logic [31:0] r_rd_count;
   logic [31:0] r_wr_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd_count <= 32'd0;
         r_wr_count <= 32'd0;
      end else if (w_go && !w_err) begin
         if (w_is_read) r_rd_count <= r_rd_count + 32'd1;
         else           r_wr_count <= r_wr_count + 32'd1;
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`else
   assign rd_count = 32'd0;
   assign wr_count = 32'd0;
`endif

endmodule
`default_nettype wire
